// File: rtl/riscv_pkg.sv
// Shared front-end types and constants for the fetch stage.
// Holds the fetch FSM encoding and the canonical NOP used for bubbles.
package riscv_pkg;

  localparam int XLEN = 64;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: downstream control, loader write port and instruction stream.
// Master drives control/loader signals; slave (the fetch unit) drives the stream.
interface instruction_fetch_unit_if #(
  parameter int IMEM_DEPTH = 64
);
  import riscv_pkg::*;

  localparam int AW = $clog2(IMEM_DEPTH);

  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            imem_we;
  logic [AW-1:0]   imem_addr;
  logic [31:0]     imem_wdata;
  logic [31:0]     instruction;
  logic [XLEN-1:0] pc_out;
  logic            instr_valid;
  logic            fault;

  modport master (
    output stall, branch_taken, branch_target, imem_we, imem_addr, imem_wdata,
    input  instruction, pc_out, instr_valid, fault
  );

  modport slave (
    input  stall, branch_taken, branch_target, imem_we, imem_addr, imem_wdata,
    output instruction, pc_out, instr_valid, fault
  );

endinterface

// File: rtl/instruction_fetch_unit_mem.sv
// Word-wide instruction store: one sync write port, one enabled sync read port.
// Read latency 1 edge; a same-edge write to the read index returns the old word.
module instruction_memory #(
  parameter int IMEM_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] waddr,
  input  logic [31:0]                   wdata,
  input  logic                          re,
  input  logic [$clog2(IMEM_DEPTH)-1:0] raddr,
  output logic [31:0]                   rdata
);

  logic [31:0] mem [IMEM_DEPTH];

  // No reset: contents survive reset so a loader can fill memory while held.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC, fetch FSM and output registers; one instruction per cycle, 1-edge latency.
// Stall freezes PC and outputs; a taken branch inserts one NOP bubble.
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              IMEM_DEPTH = 64,
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  instruction_fetch_unit_if.slave  fif
);

  localparam int AW = $clog2(IMEM_DEPTH);

  fetch_state_t    state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_out_q;
  logic            valid_q;
  logic            fault_q;
  logic            nop_sel_q;

  logic            fetch_go;
  logic [AW-1:0]   rd_idx;
  logic [31:0]     rd_data;

  assign fetch_go = (state == FETCH) && !fif.branch_taken && !fif.stall;
  assign rd_idx   = pc_q[AW+1:2];

  instruction_memory #(
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_imem (
    .clk   (clk),
    .we    (fif.imem_we),
    .waddr (fif.imem_addr),
    .wdata (fif.imem_wdata),
    .re    (fetch_go),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  // The memory read register is only loaded on a real fetch, so it already
  // holds across stalls; nop_sel_q substitutes the bubble/reset NOP.
  assign fif.instruction = nop_sel_q ? NOP_INSTR : rd_data;
  assign fif.pc_out      = pc_out_q;
  assign fif.instr_valid = valid_q;
  assign fif.fault       = fault_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pc_q      <= RESET_PC;
      pc_out_q  <= RESET_PC;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      nop_sel_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          if (fif.branch_taken) begin
            valid_q   <= 1'b0;
            nop_sel_q <= 1'b1;
            if (is_word_aligned(fif.branch_target)) begin
              pc_q <= fif.branch_target;
            end else begin
              fault_q <= 1'b1;
              state   <= HALT;
            end
          end else if (!fif.stall) begin
            pc_out_q  <= pc_q;
            valid_q   <= 1'b1;
            nop_sel_q <= 1'b0;
            pc_q      <= pc_q + XLEN'(4);
          end
        end
        HALT: begin
          valid_q <= 1'b0;
          fault_q <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front-end fetch stage that produces the 32-bit `instruction` stream consumed by the decode/register-file top level. It holds the program counter, reads a word-addressed instruction memory, presents one instruction per cycle with a valid flag, and honours stall and branch-redirect requests from downstream. A side write port lets the bench or a loader fill the memory before execution.

## Interface
- `IMEM_DEPTH`, 64: instruction memory depth in 32-bit words; power of two.
- `RESET_PC`, 64'h0: PC value loaded on reset; must be 4-byte aligned.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `stall`  in  1  downstream not ready; hold all outputs and PC.
- `branch_taken`  in  1  redirect fetch to `branch_target` this edge.
- `branch_target`  in  64  byte address of the redirect.
- `imem_we`  in  1  instruction memory write enable.
- `imem_addr`  in  log2(IMEM_DEPTH)  word index to write.
- `imem_wdata`  in  32  word to write.
- `instruction`  out  32  fetched instruction, registered.
- `pc_out`  out  64  byte address of `instruction`.
- `instr_valid`  out  1  `instruction`/`pc_out` are a real fetch.
- `fault`  out  1  sticky misaligned-branch flag.

## Operation
- Internal `pc_q` (64 b) is the next fetch address. Word index = `pc_q[log2(IMEM_DEPTH)+1:2]`. Higher bits are ignored, so the index wraps modulo IMEM_DEPTH.
- FSM states: IDLE, FETCH, HALT.
- Reset values: state=IDLE, `pc_q`=RESET_PC, `instruction`=32'h00000013 (NOP), `pc_out`=RESET_PC, `instr_valid`=0, `fault`=0. Memory contents are not reset.
- IDLE: at the first edge after reset release, go to FETCH. `instr_valid` stays 0.
- FETCH, edge priority is branch, then stall, then normal:
  - `branch_taken`=1 with `branch_target[1:0]`==0: `instruction`<=NOP, `instr_valid`<=0, `pc_q`<=`branch_target`. This is a one-cycle bubble. Branch wins over a simultaneous `stall`.
  - `branch_taken`=1 with `branch_target[1:0]`!=0: `fault`<=1, `instr_valid`<=0, `instruction`<=NOP, `pc_q` unchanged, go to HALT.
  - `stall`=1: hold `instruction`, `pc_out`, `instr_valid` and `pc_q`.
  - otherwise: `instruction`<=imem[index], `pc_out`<=`pc_q`, `instr_valid`<=1, `pc_q`<=`pc_q`+4. The add is modulo 2^64.
- HALT: all outputs are held with `instr_valid`=0 and `fault`=1. Only reset leaves HALT.
- Memory write occurs at the edge when `imem_we`=1. It is accepted in every state, including while `reset`=0.
- A same-edge write and read at the same index returns the old word (read-before-write).

## Timing
- Fetch latency is 1 edge: the `pc_q` value before edge k appears on `pc_out` with its instruction after edge k.
- Sustained throughput is 1 instruction per cycle with no stall or branch.
- Each taken branch costs exactly one bubble cycle. The first instruction from the target is valid at the second edge after the branch edge.
- `stall` is sampled each edge and takes effect at that same edge. There are no outputs combinational from inputs.
- Reset asserted at any time (mid-branch, mid-stall, in HALT) forces every output to its reset value immediately, without waiting for `clk`.
- After release, the first valid instruction appears at the second rising edge.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN`=64;
  - `NOP_INSTR`=32'h00000013;
  - the fetch state enum (IDLE, FETCH, HALT).
- Sub-module `instruction_memory` has one synchronous write port and one synchronous read port with read-before-write behaviour, parameterised by IMEM_DEPTH.
- PC, FSM and output registers stay in `instruction_fetch_unit`.

## Test plan
- Load imem[0]=32'h01548133 and imem[1]=32'h00A00093, then release reset:
  - edge 1: `instr_valid`=0;
  - edge 2: `instruction`=01548133, `pc_out`=0, valid=1;
  - edge 3: `instruction`=00A00093, `pc_out`=4.
- Assert `stall` for 3 cycles after `pc_out`=4: outputs are frozen at 00A00093/4. On the first edge after release, `pc_out`=8 with imem[2].
- Assert `branch_taken` with target 0x10 and `stall`=1 on the same edge:
  - next edge: valid=0, `instruction`=NOP;
  - following edge: `pc_out`=0x10, `instruction`=imem[4].
- Branch target 0x6: `fault`=1, valid=0, state HALT persists 5+ cycles. Driving `reset` low mid-cycle clears `fault` and outputs before the next `clk` edge.
- Wrap with IMEM_DEPTH=64, running through `pc_out`=0xFC: the next fetch has `pc_out`=0x100 and `instruction`=imem[0].
- Write imem[3]=32'hDEADBEEF on the same edge that fetches index 3: the old word is returned. A branch back to 0xC then returns DEADBEEF.
